alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Does not use its own adder. It borrows the shared 32-bit ALU through a request/grant port and issues one ADD or SUB per granted cycle.
- Shifting, comparison and sign bookkeeping are local.
- Sits beside the execute stage. The core stalls on req_ready/rsp_valid.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/alu_muldiv_seq_if.sv | 26 ++
 rtl/muldiv_step.sv | 79 +++++++
 rtl/alu_muldiv_seq.sv | 102 ++++++++++
 tb/tb_alu_muldiv_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and ALU codes for the RV32M sequencer
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
    OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111
  } op_e;
  function automatic logic a_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic b_signed(op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: request/response handshake plus shared-ALU borrow port
interface alu_muldiv_seq_if;
  import muldiv_pkg::*;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            alu_req;
  logic            alu_gnt;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_gnt, alu_result,
    input  req_ready, rsp_valid, rsp_result, alu_req, alu_a, alu_b, alu_ctrl
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_gnt, alu_result,
    output req_ready, rsp_valid, rsp_result, alu_req, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: per-state ALU operand selection and next datapath values
module muldiv_step
  import muldiv_pkg::*;
(
  input  state_e          state,
  input  op_e             op,
  input  logic            neg_a,
  input  logic            neg_b,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] bmag,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt,
  output logic [XLEN-1:0] bmag_nxt
);
  logic            is_div;
  logic            is_rem;
  logic            neg_res;
  logic            ge;
  logic            carry;
  logic [XLEN:0]   rp;
  logic [XLEN-1:0] b_sel;
  logic [XLEN-1:0] word;
  assign is_div  = op[2];
  assign is_rem  = op inside {OP_REM, OP_REMU};
  assign neg_res = is_rem ? neg_a : neg_a ^ neg_b;
  assign rp      = {hi, lo[XLEN-1]};
  assign ge      = rp >= {1'b0, bmag};
  assign b_sel   = lo[0] ? bmag : '0;
  assign carry   = (hi[XLEN-1] & b_sel[XLEN-1]) | ((hi[XLEN-1] | b_sel[XLEN-1]) & ~alu_result[XLEN-1]);
  assign word    = is_rem ? hi : lo;
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    hi_nxt   = hi;
    lo_nxt   = lo;
    bmag_nxt = bmag;
    case (state)
      ABS_A: begin
        alu_a    = neg_a ? '0 : lo;
        alu_b    = neg_a ? lo : '0;
        alu_ctrl = neg_a ? ALU_SUB : ALU_ADD;
        lo_nxt   = alu_result;
      end
      ABS_B: begin
        alu_a    = neg_b ? '0 : hi;
        alu_b    = neg_b ? hi : '0;
        alu_ctrl = neg_b ? ALU_SUB : ALU_ADD;
        bmag_nxt = alu_result;
        hi_nxt   = '0;
      end
      ITER: begin
        alu_a    = is_div ? rp[XLEN-1:0] : hi;
        alu_b    = is_div ? bmag : b_sel;
        alu_ctrl = is_div ? ALU_SUB : ALU_ADD;
        hi_nxt   = is_div ? (ge ? alu_result : rp[XLEN-1:0]) : {carry, alu_result[XLEN-1:1]};
        lo_nxt   = is_div ? {lo[XLEN-2:0], ge} : {alu_result[0], lo[XLEN-1:1]};
      end
      FIX_LO: begin
        alu_a    = neg_res ? '0 : word;
        alu_b    = neg_res ? word : '0;
        alu_ctrl = neg_res ? ALU_SUB : ALU_ADD;
        hi_nxt   = is_rem ? alu_result : hi;
        lo_nxt   = is_rem ? lo : alu_result;
      end
      FIX_HI: begin
        alu_a    = neg_res ? ~hi : hi;
        alu_b    = neg_res ? {{(XLEN-1){1'b0}}, lo == '0} : '0;
        hi_nxt   = alu_result;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: RV32M multiply/divide sequencer borrowing the shared ALU
module alu_muldiv_seq
  import muldiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_muldiv_seq_if.slave    bus
);
  state_e          state;
  state_e          state_nxt;
  op_e             op;
  op_e             req_op;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] bmag;
  logic [XLEN-1:0] hi_s;
  logic [XLEN-1:0] lo_s;
  logic [XLEN-1:0] bmag_s;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [4:0]      cnt;
  logic            accept;
  logic            adv;
  logic            b_zero;
  logic            ovf;
  logic            special;
  assign req_op  = op_e'(bus.req_op);
  assign accept  = bus.req_valid && state == IDLE && !flush;
  assign adv     = bus.alu_gnt && bus.alu_req && !flush;
  assign b_zero  = bus.req_b == '0;
  assign ovf     = req_op inside {OP_DIV, OP_REM} && bus.req_a == 32'h8000_0000 && bus.req_b == '1;
  assign special = req_op[2] && (b_zero || ovf);
  muldiv_step u_step (
    .state      (state),
    .op         (op),
    .neg_a      (neg_a),
    .neg_b      (neg_b),
    .hi         (hi),
    .lo         (lo),
    .bmag       (bmag),
    .alu_result (bus.alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .hi_nxt     (hi_s),
    .lo_nxt     (lo_s),
    .bmag_nxt   (bmag_s)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (special ? DONE : ABS_A) : IDLE;
      ABS_A:   state_nxt = bus.alu_gnt ? ABS_B : ABS_A;
      ABS_B:   state_nxt = bus.alu_gnt ? ITER : ABS_B;
      ITER:    state_nxt = bus.alu_gnt && cnt == '0 ? FIX_LO : ITER;
      FIX_LO:  state_nxt = bus.alu_gnt ? (op[2] ? DONE : FIX_HI) : FIX_LO;
      FIX_HI:  state_nxt = bus.alu_gnt ? DONE : FIX_HI;
      DONE:    state_nxt = bus.rsp_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op    <= OP_MUL;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      bmag  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      op    <= req_op;
      neg_a <= bus.req_a[XLEN-1] && a_signed(req_op);
      neg_b <= bus.req_b[XLEN-1] && b_signed(req_op);
      hi    <= special ? (b_zero ? bus.req_a : '0) : bus.req_b;
      lo    <= special ? (b_zero ? '1 : 32'h8000_0000) : bus.req_a;
    end else if (adv) begin
      hi    <= hi_s;
      lo    <= lo_s;
      bmag  <= bmag_s;
      cnt   <= state == ABS_B ? 5'd31 : (state == ITER ? cnt - 5'd1 : cnt);
    end
  end
  always_comb begin
    bus.req_ready  = state == IDLE;
    bus.rsp_valid  = state == DONE;
    bus.alu_req    = state inside {ABS_A, ABS_B, ITER, FIX_LO, FIX_HI};
    bus.rsp_result = state != DONE ? '0 : (op == OP_MUL || op[2:1] == 2'b10 ? lo : hi);
    bus.alu_a      = alu_a;
    bus.alu_b      = alu_b;
    bus.alu_ctrl   = alu_ctrl;
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: scoreboard bench for the RV32M sequencer with a behavioural ALU
module tb_alu_muldiv_seq;
  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          acc;
    int          gl0;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   gl = 0;
  int   acc_cyc = 0;
  bit   rnd_gnt = 0;
  exp_t q[$];
  alu_muldiv_seq_if bus ();
  alu_muldiv_seq dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.alu_result = bus.alu_ctrl == 4'b0110 ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    logic        was_low;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [3:0]  pc;
    was_low = 0;
    pa = 0;
    pb = 0;
    pc = 0;
    bus.alu_gnt = 1'b1;
    forever begin
      @(negedge clk);
      if (was_low && rst_n) begin
        chk("frozen_alu_a", bus.alu_a, pa);
        chk("frozen_alu_b", bus.alu_b, pb);
        chk("frozen_alu_ctrl", {28'b0, bus.alu_ctrl}, {28'b0, pc});
      end
      bus.alu_gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      was_low = bus.alu_req && !bus.alu_gnt && !flush;
      if (was_low) gl++;
      pa = bus.alu_a;
      pb = bus.alu_b;
      pc = bus.alu_ctrl;
    end
  end
  initial begin
    exp_t e;
    bit   seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got result %h with nothing outstanding", bus.rsp_result);
        end else begin
          e = q[0];
          if (!seen) begin
            seen = 1;
            chk("latency", 32'(cyc - e.acc), 32'(e.lat + gl - e.gl0));
          end
          chk("rsp_result", bus.rsp_result, e.exp);
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            seen = 0;
          end else chk("req_ready_in_done", {31'b0, bus.req_ready}, 32'd0);
        end
      end
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit track);
    int t = 0;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    acc_cyc = cyc + 1;
    if (track) q.push_back('{exp, lat, cyc + 1, gl});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(op, a, b, exp, lat, 1'b1);
    drain();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int t;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 3'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_alu_req", {31'b0, bus.alu_req}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_ctrl", {28'b0, bus.alu_ctrl}, 32'h2);
    rst_n = 1'b1;
    @(negedge clk);
    run(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 36);
    run(3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 36);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 36);
    run(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 36);
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35);
    run(3'b111, 32'd100, 32'd7, 32'd2, 35);
    run(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run(3'b110, 32'd5, 32'd0, 32'd5, 0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    rnd_gnt = 1;
    run(3'b000, 32'd12345, 32'd678, 32'd8369910, 36);
    rnd_gnt = 0;
    repeat (2) @(negedge clk);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 1'b0);
    while (cyc < acc_cyc + 23) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("flush_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("flush_alu_req", {31'b0, bus.alu_req}, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'b100, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("arst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("arst_rsp_result", bus.rsp_result, 32'd0);
    chk("arst_alu_req", {31'b0, bus.alu_req}, 32'd0);
    chk("arst_alu_ctrl", {28'b0, bus.alu_ctrl}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.rsp_ready = 1'b0;
    issue(3'b000, 32'd6, 32'd7, 32'd42, 36, 1'b1);
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("after_hold_req_ready", {31'b0, bus.req_ready}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
